// File: rtl/aes_round_ctrl.sv
// AES control FSM for 128/192/256-bit keys: full encrypt, full decrypt and key expansion.
// Defining AES_ROUND_CTRL_ABORT_EN adds abort_i, which returns any busy state to IDLE.
module aes_round_ctrl #(
   parameter int KEY_BITS = 128,
   parameter int RND_W    = 4
) (
   input  logic             clk,
   input  logic             rst,
`ifdef AES_ROUND_CTRL_ABORT_EN
   input  logic             abort_i,
`endif
   input  logic             start_i,
   input  logic [1:0]       op_i,
   output logic             ready_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o,
   output logic             key_valid_o,
   output logic [RND_W-1:0] round_o,
   output logic             zero_rnd_o,
   output logic             en_rnd_o,
   output logic             final_rnd_o,
   output logic             inv_o,
   output logic             key_wr_en_o,
   output logic [5:0]       key_word_idx_o,
   output logic             key_rot_o,
   output logic             key_sub_o,
   output logic [7:0]       rcon_o
);

   localparam int NK       = KEY_BITS / 32;
   localparam int NR       = NK + 6;
   localparam int LAST_IDX = 4 * (NR + 1) - 1;

   localparam logic [1:0] OP_NOOP = 2'b00;
   localparam logic [1:0] OP_ENC  = 2'b01;
   localparam logic [1:0] OP_DEC  = 2'b10;
   localparam logic [1:0] OP_KEY  = 2'b11;

   localparam logic [RND_W-1:0] RND_ZERO  = '0;
   localparam logic [RND_W-1:0] RND_ONE   = RND_W'(1);
   localparam logic [RND_W-1:0] RND_NR    = RND_W'(NR);
   localparam logic [RND_W-1:0] RND_NRM1  = RND_W'(NR - 1);
   localparam logic [5:0]       IDX_FIRST = 6'(NK);
   localparam logic [5:0]       IDX_LAST  = 6'(LAST_IDX);
   localparam logic [2:0]       MOD_LAST  = 3'(NK - 1);
   localparam bit               IS_256    = (NK == 8);

   generate
      if (!(KEY_BITS == 128 || KEY_BITS == 192 || KEY_BITS == 256)) begin : g_bad_key
         $fatal(1, "aes_round_ctrl: KEY_BITS must be 128, 192 or 256");
      end
      if (NR >= (1 << RND_W)) begin : g_bad_rnd_w
         $fatal(1, "aes_round_ctrl: RND_W too narrow to hold NR");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE, S_INIT, S_ROUND, S_FINAL, S_EXPAND, S_DONE
   } state_e;

   state_e           state_q;
   logic             ready_q, done_q, err_q, key_valid_q;
   logic [RND_W-1:0] round_q;
   logic             zero_q, en_q, final_q, inv_q;
   logic             wr_en_q, rot_q, sub_q;
   logic [5:0]       idx_q;
   logic [7:0]       rcon_out_q;
   logic [7:0]       rcon_q, rcon_d;
   logic [2:0]       mod_q, mod_d;
   logic             abort_w;

`ifdef AES_ROUND_CTRL_ABORT_EN
   assign abort_w = abort_i;
`else
   assign abort_w = 1'b0;
`endif

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // mod_q tracks (word index mod NK) so no divider is needed.
   always_comb begin
      mod_d  = (mod_q == MOD_LAST) ? 3'd0 : mod_q + 3'd1;
      rcon_d = rcon_q;
      if (state_q == S_IDLE && start_i && op_i == OP_KEY)
         rcon_d = 8'h01;
      else if (state_q == S_EXPAND && rot_q)
         rcon_d = xtime(rcon_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         ready_q     <= 1'b1;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         key_valid_q <= 1'b0;
         round_q     <= '0;
         zero_q      <= 1'b0;
         en_q        <= 1'b0;
         final_q     <= 1'b0;
         inv_q       <= 1'b0;
         wr_en_q     <= 1'b0;
         rot_q       <= 1'b0;
         sub_q       <= 1'b0;
         idx_q       <= '0;
         rcon_out_q  <= '0;
         rcon_q      <= 8'h01;
         mod_q       <= '0;
      end else begin
         rcon_q <= rcon_d;
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start_i && (op_i == OP_ENC || op_i == OP_DEC)) begin
                  if (key_valid_q) begin
                     state_q <= S_INIT;
                     ready_q <= 1'b0;
                     inv_q   <= (op_i == OP_DEC);
                     round_q <= (op_i == OP_DEC) ? RND_NR : RND_ZERO;
                     zero_q  <= 1'b1;
                  end else begin
                     err_q <= 1'b1;
                  end
               end else if (start_i && op_i == OP_KEY) begin
                  state_q     <= S_EXPAND;
                  ready_q     <= 1'b0;
                  key_valid_q <= 1'b0;
                  wr_en_q     <= 1'b1;
                  idx_q       <= IDX_FIRST;
                  mod_q       <= 3'd0;
                  rot_q       <= 1'b1;
                  sub_q       <= 1'b1;
                  rcon_out_q  <= 8'h01;
               end
            end
            S_INIT: begin
               state_q <= S_ROUND;
               zero_q  <= 1'b0;
               en_q    <= 1'b1;
               round_q <= inv_q ? RND_NRM1 : RND_ONE;
            end
            S_ROUND: begin
               if (inv_q ? (round_q == RND_ONE) : (round_q == RND_NRM1)) begin
                  state_q <= S_FINAL;
                  en_q    <= 1'b0;
                  final_q <= 1'b1;
                  round_q <= inv_q ? RND_ZERO : RND_NR;
               end else begin
                  round_q <= inv_q ? round_q - RND_ONE : round_q + RND_ONE;
               end
            end
            S_FINAL: begin
               state_q <= S_DONE;
               final_q <= 1'b0;
               round_q <= '0;
               done_q  <= 1'b1;
            end
            S_EXPAND: begin
               if (idx_q == IDX_LAST) begin
                  state_q     <= S_DONE;
                  done_q      <= 1'b1;
                  key_valid_q <= 1'b1;
                  wr_en_q     <= 1'b0;
                  rot_q       <= 1'b0;
                  sub_q       <= 1'b0;
                  idx_q       <= '0;
                  rcon_out_q  <= '0;
               end else begin
                  // Outputs for the next word; rcon_d already holds its advanced value.
                  idx_q      <= idx_q + 6'd1;
                  mod_q      <= mod_d;
                  rot_q      <= (mod_d == 3'd0);
                  sub_q      <= (mod_d == 3'd0) || (IS_256 && mod_d == 3'd4);
                  rcon_out_q <= (mod_d == 3'd0) ? rcon_d : 8'h00;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               ready_q <= 1'b1;
               inv_q   <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               ready_q <= 1'b1;
            end
         endcase

         // Abort wins over everything; key_valid_q is already 0 while expanding.
         if (abort_w && state_q != S_IDLE) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            key_valid_q <= key_valid_q;
            round_q     <= '0;
            zero_q      <= 1'b0;
            en_q        <= 1'b0;
            final_q     <= 1'b0;
            inv_q       <= 1'b0;
            wr_en_q     <= 1'b0;
            rot_q       <= 1'b0;
            sub_q       <= 1'b0;
            idx_q       <= '0;
            rcon_out_q  <= '0;
         end
      end
   end

   assign ready_o        = ready_q;
   assign busy_o         = ~ready_q;
   assign done_o         = done_q;
   assign err_o          = err_q;
   assign key_valid_o    = key_valid_q;
   assign round_o        = round_q;
   assign zero_rnd_o     = zero_q;
   assign en_rnd_o       = en_q;
   assign final_rnd_o    = final_q;
   assign inv_o          = inv_q;
   assign key_wr_en_o    = wr_en_q;
   assign key_word_idx_o = idx_q;
   assign key_rot_o      = rot_q;
   assign key_sub_o      = sub_q;
   assign rcon_o         = rcon_out_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Scoreboard bench for aes_round_ctrl: three instances (128/192/256-bit keys), one driven at a time.
module tb_aes_round_ctrl;

   localparam int N = 3;
   localparam logic [1:0] OP_NOOP = 2'b00;
   localparam logic [1:0] OP_ENC  = 2'b01;
   localparam logic [1:0] OP_DEC  = 2'b10;
   localparam logic [1:0] OP_KEY  = 2'b11;
   localparam longint IDLE = longint'(1) << 29;
   localparam longint KV   = longint'(1) << 25;
   localparam int K_ERR = 1, K_RND = 2, K_WORD = 3, K_DONE = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] op_v = 2'b00;
   logic       start_v [N];
`ifdef AES_ROUND_CTRL_ABORT_EN
   logic       abort_v [N];
`endif

   logic       ready_w [N], busy_w [N], done_w [N], err_w [N], kv_w [N];
   logic       zero_w [N], en_w [N], fin_w [N], inv_w [N];
   logic       wr_w [N], rot_w [N], sub_w [N];
   logic [3:0] round_w [N];
   logic [5:0] idx_w [N];
   logic [7:0] rcon_w [N];

   typedef struct {
      int kind;
      int cyc;
      int pay;
   } rec_t;
   rec_t q[$];

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int sel = 0;
   int base = 0;
   int rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_dut
         aes_round_ctrl #(.KEY_BITS(128 + 64 * gi), .RND_W(4)) u_dut (
            .clk            (clk),
            .rst            (rst),
`ifdef AES_ROUND_CTRL_ABORT_EN
            .abort_i        (abort_v[gi]),
`endif
            .start_i        (start_v[gi]),
            .op_i           (op_v),
            .ready_o        (ready_w[gi]),
            .busy_o         (busy_w[gi]),
            .done_o         (done_w[gi]),
            .err_o          (err_w[gi]),
            .key_valid_o    (kv_w[gi]),
            .round_o        (round_w[gi]),
            .zero_rnd_o     (zero_w[gi]),
            .en_rnd_o       (en_w[gi]),
            .final_rnd_o    (fin_w[gi]),
            .inv_o          (inv_w[gi]),
            .key_wr_en_o    (wr_w[gi]),
            .key_word_idx_o (idx_w[gi]),
            .key_rot_o      (rot_w[gi]),
            .key_sub_o      (sub_w[gi]),
            .rcon_o         (rcon_w[gi])
         );
      end
   endgenerate

   function automatic longint outs(int i);
      return longint'({ready_w[i], busy_w[i], done_w[i], err_w[i], kv_w[i], zero_w[i], en_w[i],
                       fin_w[i], inv_w[i], wr_w[i], rot_w[i], sub_w[i], round_w[i], idx_w[i],
                       rcon_w[i]});
   endfunction

   task automatic chk(string name, longint got, longint exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, got, exp);
      end
   endtask

   task automatic push(int kind, int c, int pay);
      rec_t r;
      r.kind = kind;
      r.cyc  = c;
      r.pay  = pay;
      q.push_back(r);
   endtask

   task automatic pop_cmp(int kind, int pay);
      rec_t r;
      n_chk++;
      if (q.size() == 0) begin
         n_fail++;
         $display("FAIL unexpected_event: got kind %0d payload %0h at cycle %0d, required no event",
                  kind, pay, cyc);
      end else begin
         r = q.pop_front();
         if (r.kind != kind || r.cyc != cyc || r.pay != pay) begin
            n_fail++;
            $display("FAIL event: got kind/cycle/payload %0d/%0d/%0h, required %0d/%0d/%0h",
                     kind, cyc, pay, r.kind, r.cyc, r.pay);
         end
      end
   endtask

   // Monitor: every strobe on the selected instance must match the queue head.
   always @(negedge clk) begin
      if (!rst) begin
         if (err_w[sel]) pop_cmp(K_ERR, int'(ready_w[sel]));
         if (zero_w[sel] || en_w[sel] || fin_w[sel])
            pop_cmp(K_RND, int'({round_w[sel], zero_w[sel], en_w[sel], fin_w[sel], inv_w[sel]}));
         if (wr_w[sel])
            pop_cmp(K_WORD, int'({idx_w[sel], rot_w[sel], sub_w[sel], rcon_w[sel]}));
         if (done_w[sel]) pop_cmp(K_DONE, int'(kv_w[sel]));
         n_chk++;
         if (busy_w[sel] === ready_w[sel] ||
             (int'(zero_w[sel]) + int'(en_w[sel]) + int'(fin_w[sel])) > 1) begin
            n_fail++;
            $display("FAIL invariant: got busy=%b ready=%b z/e/f=%b%b%b, required busy=~ready and one strobe max",
                     busy_w[sel], ready_w[sel], zero_w[sel], en_w[sel], fin_w[sel]);
         end
      end
   end

   task automatic issue(int inst, logic [1:0] op);
      sel = inst;
      op_v = op;
      start_v[inst] = 1'b1;
      base = cyc;
      $display("issue inst=%0d op=%0d at cycle %0d", inst, op, cyc);
   endtask

   task automatic step();
      @(negedge clk);
      start_v[sel] = 1'b0;
   endtask

   task automatic wait_idle(string name);
      int n = 0;
      while ((q.size() != 0 || !ready_w[sel]) && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_timeout"}, longint'(n >= 300), 0);
   endtask

   task automatic exp_cipher(int nr, bit dec, int b);
      push(K_RND, b + 1, ((dec ? nr : 0) << 4) | 8 | int'(dec));
      for (int r = 1; r < nr; r++)
         push(K_RND, b + 1 + r, ((dec ? nr - r : r) << 4) | 4 | int'(dec));
      push(K_RND, b + nr + 1, ((dec ? 0 : nr) << 4) | 2 | int'(dec));
      push(K_DONE, b + nr + 2, 1);
   endtask

   task automatic exp_expand(int nk, int b);
      int last = 4 * (nk + 7) - 1;
      for (int i = nk; i <= last; i++) begin
         bit rot = (i % nk == 0);
         bit sub = rot || (nk == 8 && i % 8 == 4);
         int rc  = rot ? rcon_tab[i / nk - 1] : 0;
         push(K_WORD, b + i - nk + 1, (i << 10) | (int'(rot) << 9) | (int'(sub) << 8) | rc);
      end
      push(K_DONE, b + last - nk + 2, 1);
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         start_v[i] = 1'b0;
`ifdef AES_ROUND_CTRL_ABORT_EN
         abort_v[i] = 1'b0;
`endif
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < N; i++) chk($sformatf("reset_state_%0d", i), outs(i), IDLE);

      // Cipher request without a key is rejected with a single err pulse.
      issue(0, OP_ENC); push(K_ERR, base + 1, 1); step();
      wait_idle("enc_nokey");
      chk("enc_nokey_idle", outs(0), IDLE);

      issue(0, OP_KEY); exp_expand(4, base); step();
      wait_idle("expand128");
      chk("expand128_kv", outs(0), IDLE | KV);

      issue(2, OP_KEY); exp_expand(8, base); step();
      wait_idle("expand256");
      chk("expand256_kv", outs(2), IDLE | KV);

      issue(1, OP_KEY); exp_expand(6, base); step();
      wait_idle("expand192");
      issue(1, OP_ENC); exp_cipher(12, 1'b0, base); step();
      wait_idle("enc192");
      issue(1, OP_DEC); exp_cipher(12, 1'b1, base); step();
      wait_idle("dec192");
      chk("dec192_idle", outs(1), IDLE | KV);

      // start held high: one op, then a second accepted the cycle after done.
      issue(0, OP_ENC);
      exp_cipher(10, 1'b0, base);
      exp_cipher(10, 1'b0, base + 13);
      repeat (14) @(negedge clk);
      start_v[0] = 1'b0;
      wait_idle("enc_held");

      issue(0, OP_NOOP); step();
      repeat (5) @(negedge clk);
      chk("noop_idle", outs(0), IDLE | KV);
      chk("noop_queue", longint'(q.size()), 0);

`ifdef AES_ROUND_CTRL_ABORT_EN
      issue(1, OP_ENC);
      push(K_RND, base + 1, 8);
      for (int r = 1; r <= 3; r++) push(K_RND, base + 1 + r, (r << 4) | 4);
      step();
      repeat (3) @(negedge clk);
      abort_v[1] = 1'b1;
      @(negedge clk);
      abort_v[1] = 1'b0;
      chk("abort_idle", outs(1), IDLE | KV);
      repeat (16) @(negedge clk);
      chk("abort_queue", longint'(q.size()), 0);
`endif

      // Reset in the middle of an expansion.
      issue(2, OP_KEY); exp_expand(8, base); step();
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      q.delete();
      for (int i = 0; i < N; i++) chk($sformatf("midreset_state_%0d", i), outs(i), IDLE);

      issue(1, OP_DEC); push(K_ERR, base + 1, 1); step();
      wait_idle("dec_after_reset");
      chk("dec_after_reset_idle", outs(1), IDLE);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion, required finish within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
